// File: rtl/mvp_pkg.sv
// Shared types and helpers for the sequential matrix-vector product:
// FSM state encoding, round/saturate result type and reset-matrix helper.
package mvp_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MAC  = 2'd1;
    localparam state_t ST_NORM = 2'd2;
    localparam state_t ST_OUT  = 2'd3;

    // Wide enough for any accumulator this block is built with (WIDTH <= 31).
    localparam int RS_W = 64;

    typedef struct packed {
        logic signed [RS_W-1:0] value;
        logic                   sat;
    } round_sat_t;

    // Round half up, arithmetic shift by frac, clamp to a signed width-bit range.
    function automatic round_sat_t round_sat(input logic signed [RS_W-1:0] acc,
                                             input int width,
                                             input int frac);
        logic signed [RS_W-1:0] half;
        logic signed [RS_W-1:0] shifted;
        logic signed [RS_W-1:0] max_v;
        logic signed [RS_W-1:0] min_v;
        round_sat_t             res;
        half    = (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
        shifted = (acc + half) >>> frac;
        max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (width - 1));
        res.value = shifted;
        res.sat   = 1'b0;
        if (shifted > max_v) begin
            res.value = max_v;
            res.sat   = 1'b1;
        end else if (shifted < min_v) begin
            res.value = min_v;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

    function automatic logic [RS_W-1:0] identity_elem(input int row,
                                                      input int col,
                                                      input int frac);
        return (row == col) ? (64'd1 << frac) : 64'd0;
    endfunction

endpackage

// File: rtl/mvp_lane.sv
// One output row: signed multiply-accumulate over the streamed columns,
// then a registered round-half-up / saturate into the output element.
module mvp_lane
    import mvp_pkg::*;
#(
    parameter int DIM   = 4,
    parameter int WIDTH = 16,
    parameter int FRAC  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             mac_en,
    input  logic             norm_en,
    input  logic [WIDTH-1:0] mat_elem,
    input  logic [WIDTH-1:0] vec_elem,
    output logic [WIDTH-1:0] result,
    output logic             sat
);

    // Headroom of $clog2(DIM) bits so DIM full-scale products never wrap.
    localparam int ACC_W = 2 * WIDTH + $clog2(DIM);

    logic signed [2*WIDTH-1:0] product;
    logic signed [ACC_W-1:0]   acc;
    round_sat_t                rs;

    assign product = (2*WIDTH)'($signed(mat_elem)) * (2*WIDTH)'($signed(vec_elem));
    assign rs      = round_sat(RS_W'(acc), WIDTH, FRAC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            result <= '0;
            sat    <= 1'b0;
        end else begin
            if (clr) begin
                acc <= '0;
            end else if (mac_en) begin
                acc <= acc + ACC_W'(product);
            end
            if (norm_en) begin
                result <= rs.value[WIDTH-1:0];
                sat    <= rs.sat;
            end
        end
    end

endmodule

// File: rtl/mvp_seq.sv
// Sequential DIMxDIM matrix times streamed vector: matrix registers, vector
// latch, column counter and IDLE/MAC/NORM/OUT sequencing around DIM MAC lanes.
module mvp_seq
    import mvp_pkg::*;
#(
    parameter int DIM   = 4,
    parameter int WIDTH = 16,
    parameter int FRAC  = 12
) (
    input  logic                         clock,
    input  logic                         io_aresetn,
    input  logic                         io_matWe,
    input  logic [$clog2(DIM*DIM)-1:0]   io_matAddr,
    input  logic [WIDTH-1:0]             io_matData,
    output logic                         io_matReady,
    input  logic                         io_inValid,
    output logic                         io_inReady,
    input  logic [DIM*WIDTH-1:0]         io_inVec,
    output logic                         io_outValid,
    input  logic                         io_outReady,
    output logic [DIM*WIDTH-1:0]         io_outVec,
    output logic                         io_outSat
);

    localparam int N     = DIM * DIM;
    localparam int COL_W = $clog2(DIM);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(DIM - 1);

    state_t               state;
    logic [COL_W-1:0]     col;
    logic [DIM*WIDTH-1:0] vec_q;
    logic [WIDTH-1:0]     mat [N];
    logic [DIM-1:0]       lane_sat;
    logic                 accept;

    // io_inReady is decoded from state only, except in OUT where it follows io_outReady.
    assign io_matReady = (state == ST_IDLE);
    assign io_inReady  = (state == ST_IDLE) || ((state == ST_OUT) && io_outReady);
    assign io_outValid = (state == ST_OUT);
    assign io_outSat   = |lane_sat;
    assign accept      = io_inValid && io_inReady;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values and the block behaves the same regardless of evaluation order.
    always_ff @(posedge clock or negedge io_aresetn) begin
        if (!io_aresetn) begin
            state <= ST_IDLE;
            col   <= '0;
            vec_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        vec_q <= io_inVec;
                        col   <= '0;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (col == COL_LAST) begin
                        col   <= '0;
                        state <= ST_NORM;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                ST_NORM: state <= ST_OUT;
                ST_OUT: begin
                    if (io_outReady) begin
                        if (io_inValid) begin
                            vec_q <= io_inVec;
                            col   <= '0;
                            state <= ST_MAC;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the matrix is a small register file, not RAM, so it is reset
    // element by element; an unreset RAM would not return to identity.
    always_ff @(posedge clock or negedge io_aresetn) begin
        if (!io_aresetn) begin
            for (int i = 0; i < N; i++) begin
                mat[i] <= WIDTH'(identity_elem(i / DIM, i % DIM, FRAC));
            end
        end else if (io_matWe && (state == ST_IDLE) && (int'(io_matAddr) < N)) begin
            mat[io_matAddr] <= io_matData;
        end
    end

    for (genvar r = 0; r < DIM; r++) begin : g_lane
        mvp_lane #(
            .DIM   (DIM),
            .WIDTH (WIDTH),
            .FRAC  (FRAC)
        ) u_lane (
            .clk      (clock),
            .rst_n    (io_aresetn),
            .clr      (accept),
            .mac_en   (state == ST_MAC),
            .norm_en  (state == ST_NORM),
            .mat_elem (mat[r * DIM + int'(col)]),
            .vec_elem (vec_q[int'(col) * WIDTH +: WIDTH]),
            .result   (io_outVec[r * WIDTH +: WIDTH]),
            .sat      (lane_sat[r])
        );
    end

endmodule

// File: tb/tb_mvp_seq.sv
// Self-checking bench for mvp_seq: directed scenarios plus randomized
// matrices/vectors checked against a plain-arithmetic reference model.
module tb_mvp_seq;

    localparam int DIM   = 4;
    localparam int WIDTH = 16;
    localparam int FRAC  = 12;
    localparam int N     = DIM * DIM;
    localparam int AW    = $clog2(N);
    localparam int LAT   = DIM + 1;

    logic                 clock = 1'b0;
    logic                 io_aresetn;
    logic                 io_matWe;
    logic [AW-1:0]        io_matAddr;
    logic [WIDTH-1:0]     io_matData;
    logic                 io_matReady;
    logic                 io_inValid;
    logic                 io_inReady;
    logic [DIM*WIDTH-1:0] io_inVec;
    logic                 io_outValid;
    logic                 io_outReady;
    logic [DIM*WIDTH-1:0] io_outVec;
    logic                 io_outSat;

    always #5 clock = ~clock;

    mvp_seq #(.DIM(DIM), .WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clock       (clock),
        .io_aresetn  (io_aresetn),
        .io_matWe    (io_matWe),
        .io_matAddr  (io_matAddr),
        .io_matData  (io_matData),
        .io_matReady (io_matReady),
        .io_inValid  (io_inValid),
        .io_inReady  (io_inReady),
        .io_inVec    (io_inVec),
        .io_outValid (io_outValid),
        .io_outReady (io_outReady),
        .io_outVec   (io_outVec),
        .io_outSat   (io_outSat)
    );

    int                   n_cmp  = 0;
    int                   n_fail = 0;
    longint               model_m [N];
    logic [DIM*WIDTH-1:0] exp_vec;
    logic                 exp_sat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic void model_identity();
        for (int i = 0; i < N; i++)
            model_m[i] = (i / DIM == i % DIM) ? (longint'(1) <<< FRAC) : 0;
    endfunction

    function automatic longint floor_div(input longint a, input longint d);
        longint q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Real-number product rounded to nearest (ties up), clamped to the element range.
    function automatic void predict(input logic [DIM*WIDTH-1:0] v);
        longint acc, q;
        longint hi = (longint'(1) <<< (WIDTH - 1)) - 1;
        longint lo = -(longint'(1) <<< (WIDTH - 1));
        exp_sat = 1'b0;
        for (int r = 0; r < DIM; r++) begin
            acc = 0;
            for (int c = 0; c < DIM; c++)
                acc += model_m[r * DIM + c] * longint'($signed(v[c * WIDTH +: WIDTH]));
            q = floor_div(acc + (longint'(1) <<< (FRAC - 1)), longint'(1) <<< FRAC);
            if (q > hi) begin q = hi; exp_sat = 1'b1; end
            if (q < lo) begin q = lo; exp_sat = 1'b1; end
            exp_vec[r * WIDTH +: WIDTH] = q[WIDTH-1:0];
        end
    endfunction

    task automatic write_mat(input int a, input logic [WIDTH-1:0] d);
        io_matWe   = 1'b1;
        io_matAddr = AW'(a);
        io_matData = d;
        @(posedge clock);
        model_m[a] = longint'($signed(d));
        @(negedge clock);
        io_matWe = 1'b0;
    endtask

    task automatic accept_vec(input string tag, input logic [DIM*WIDTH-1:0] v,
                              input bit do_wr, input int a, input logic [WIDTH-1:0] d);
        int waits = 0;
        io_inVec   = v;
        io_inValid = 1'b1;
        if (do_wr) begin
            io_matWe   = 1'b1;
            io_matAddr = AW'(a);
            io_matData = d;
        end
        while (!io_inReady && waits < 50) begin
            @(posedge clock);
            @(negedge clock);
            waits++;
        end
        check({tag, "_in_ready"}, 64'(io_inReady), 64'd1);
        @(posedge clock);
        if (do_wr) model_m[a] = longint'($signed(d));
        predict(v);
        @(negedge clock);
        io_inValid = 1'b0;
        io_matWe   = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int edges = 0;
        while (!io_outValid && edges < 20) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
        check({tag, "_latency"}, 64'(edges), 64'(LAT));
        check({tag, "_vec"}, 64'(io_outVec), 64'(exp_vec));
        check({tag, "_sat"}, 64'(io_outSat), 64'(exp_sat));
    endtask

    task automatic consume(input string tag);
        io_outReady = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check({tag, "_drained"}, 64'(io_outValid), 64'd0);
    endtask

    task automatic run_vec(input string tag, input logic [DIM*WIDTH-1:0] v);
        accept_vec(tag, v, 1'b0, 0, '0);
        wait_result(tag);
        consume(tag);
    endtask

    function automatic logic [DIM*WIDTH-1:0] splat(input logic [WIDTH-1:0] e);
        return {DIM{e}};
    endfunction

    function automatic logic [WIDTH-1:0] rand_elem();
        logic [WIDTH-1:0] e = WIDTH'($urandom);
        if ($urandom_range(0, 2) != 0) e = {{(WIDTH-13){e[12]}}, e[12:0]};
        return e;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DIM*WIDTH-1:0] v;
        bit saw_valid;

        io_aresetn  = 1'b0;
        io_matWe    = 1'b0;
        io_matAddr  = '0;
        io_matData  = '0;
        io_inValid  = 1'b0;
        io_inVec    = '0;
        io_outReady = 1'b1;
        model_identity();
        repeat (3) @(negedge clock);
        check("rst_out_valid", 64'(io_outValid), 64'd0);
        check("rst_out_vec", 64'(io_outVec), 64'd0);
        check("rst_out_sat", 64'(io_outSat), 64'd0);
        io_aresetn = 1'b1;
        @(negedge clock);
        check("idle_in_ready", 64'(io_inReady), 64'd1);
        check("idle_mat_ready", 64'(io_matReady), 64'd1);

        // Identity matrix passes the vector through unchanged.
        run_vec("ident", {16'h0001, 16'hF000, 16'h1000, 16'h0800});

        // All-0.5 matrix: 4 * 0.25 = 1.0, and half-LSB rounds up to 1.
        for (int i = 0; i < N; i++) write_mat(i, 16'h0800);
        run_vec("half_all", splat(16'h0800));
        run_vec("half_lsb", {16'h0000, 16'h0000, 16'h0000, 16'h0001});

        // Full-scale saturation in both directions.
        for (int i = 0; i < N; i++) write_mat(i, 16'h7FFF);
        run_vec("sat_pos", splat(16'h7FFF));
        run_vec("sat_neg", splat(16'h8000));

        // Back-pressure with a random matrix; writes during MAC must be ignored.
        for (int i = 0; i < N; i++) write_mat(i, rand_elem());
        io_outReady = 1'b0;
        accept_vec("bp1", {rand_elem(), rand_elem(), rand_elem(), rand_elem()}, 1'b0, 0, '0);
        wait_result("bp1");
        for (int k = 0; k < 10; k++) begin
            @(posedge clock);
            @(negedge clock);
            check("bp_hold_vec", 64'(io_outVec), 64'(exp_vec));
            check("bp_hold_valid", 64'(io_outValid), 64'd1);
            check("bp_in_ready", 64'(io_inReady), 64'd0);
            check("bp_mat_ready", 64'(io_matReady), 64'd0);
        end
        v = {rand_elem(), rand_elem(), rand_elem(), rand_elem()};
        io_inVec    = v;
        io_inValid  = 1'b1;
        io_outReady = 1'b1;
        #1;
        check("bp_in_ready_follow", 64'(io_inReady), 64'd1);
        @(posedge clock);
        predict(v);
        @(negedge clock);
        io_inValid = 1'b0;
        io_matWe   = 1'b1;
        io_matAddr = '0;
        io_matData = 16'h5A5A;
        wait_result("bp2");
        io_matWe = 1'b0;
        consume("bp2");
        run_vec("bp_mat_kept", {rand_elem(), rand_elem(), rand_elem(), rand_elem()});

        // Same-cycle write and accept: the accepted vector sees the new element.
        for (int i = 0; i < N; i++)
            write_mat(i, (i / DIM == i % DIM) ? 16'h1000 : 16'h0000);
        accept_vec("wr_acc", {16'h0000, 16'h0000, 16'h0000, 16'h1000}, 1'b1, 0, 16'h2000);
        wait_result("wr_acc");
        check("wr_acc_out0", 64'(io_outVec[WIDTH-1:0]), 64'h2000);
        consume("wr_acc");

        // Reset during MAC discards the vector and restores identity.
        accept_vec("rst_mid", splat(16'h1234), 1'b0, 0, '0);
        @(posedge clock);
        @(negedge clock);
        io_aresetn = 1'b0;
        @(negedge clock);
        io_aresetn = 1'b1;
        model_identity();
        saw_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (io_outValid) saw_valid = 1'b1;
        end
        check("rst_mid_no_output", 64'(saw_valid), 64'd0);
        check("rst_mid_vec_cleared", 64'(io_outVec), 64'd0);
        run_vec("rst_mid_ident", {16'h0800, 16'hF800, 16'h0123, 16'h7FFF});

        // Randomized traffic: sporadic writes, random vectors, random stalls.
        for (int it = 0; it < 30; it++) begin
            int nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) write_mat($urandom_range(0, N - 1), rand_elem());
            io_outReady = 1'($urandom_range(0, 1));
            v = {rand_elem(), rand_elem(), rand_elem(), rand_elem()};
            if ($urandom_range(0, 3) == 0)
                accept_vec("rnd", v, 1'b1, $urandom_range(0, N - 1), rand_elem());
            else
                accept_vec("rnd", v, 1'b0, 0, '0);
            wait_result("rnd");
            repeat ($urandom_range(0, 3)) begin
                @(posedge clock);
                @(negedge clock);
                if (!io_outReady) check("rnd_hold", 64'(io_outVec), 64'(exp_vec));
            end
            consume("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
